// File: rtl/fcpu_pkg.sv
// Shared widths and opcode encodings for the fcpu core.
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 16;
  localparam int INSTR_W  = 6;

  localparam logic [INSTR_W-1:0] I_LOAD   = 6'd1;
  localparam logic [INSTR_W-1:0] I_STORE  = 6'd2;
  localparam logic [INSTR_W-1:0] I_INPUT  = 6'd3;
  localparam logic [INSTR_W-1:0] I_OUTPUT = 6'd4;

endpackage

// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter feeding the single MMU request port through a
// one-entry registered output stage with valid/ready handshake.
module mem_request_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*RSV_ID_W-1:0]   req_rsv_id,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  input  logic [N_REQ*DATA_W-1:0]     req_address,
  input  logic [N_REQ*INSTR_W-1:0]    req_opcode,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        mmu_valid,
  output logic [RSV_ID_W-1:0]         mmu_rsv_id,
  output logic [DATA_W-1:0]           mmu_data,
  output logic [DATA_W-1:0]           mmu_address,
  output logic [INSTR_W-1:0]          mmu_opcode,
  input  logic                        mmu_ready,
  output logic [IDX_W-1:0]            grant_idx,
  output logic [IDX_W-1:0]            ptr
);

  logic                valid_q, valid_d;
  logic [RSV_ID_W-1:0] rsv_id_q, rsv_id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   address_q, address_d;
  logic [INSTR_W-1:0]  opcode_q, opcode_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  logic                found_s;
  logic [IDX_W-1:0]    win_s;
  logic                slot_free_s;
  logic                accept_s;
  logic                drain_s;

  // Rotating priority search starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        win_s   = IDX_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign slot_free_s = !valid_q || mmu_ready;
  assign drain_s     = valid_q && mmu_ready;
  assign accept_s    = found_s && slot_free_s && !nrst;

  // One-hot ready toward the selected requester only.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Output stage next state: reset, load winner, drain, or hold.
  always_comb begin
    valid_d   = valid_q;
    rsv_id_d  = rsv_id_q;
    data_d    = data_q;
    address_d = address_q;
    opcode_d  = opcode_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    if (nrst) begin
      valid_d   = 1'b0;
      rsv_id_d  = '0;
      data_d    = '0;
      address_d = '0;
      opcode_d  = '0;
      grant_d   = '0;
      ptr_d     = '0;
    end else if (accept_s) begin
      valid_d   = 1'b1;
      rsv_id_d  = req_rsv_id[int'(win_s)*RSV_ID_W +: RSV_ID_W];
      data_d    = req_data[int'(win_s)*DATA_W +: DATA_W];
      address_d = req_address[int'(win_s)*DATA_W +: DATA_W];
      opcode_d  = req_opcode[int'(win_s)*INSTR_W +: INSTR_W];
      grant_d   = win_s;
      ptr_d     = (win_s == IDX_W'(N_REQ - 1)) ? '0 : win_s + 1'b1;
    end else if (drain_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage and priority pointer registers.
  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    rsv_id_q  <= rsv_id_d;
    data_q    <= data_d;
    address_q <= address_d;
    opcode_q  <= opcode_d;
    grant_q   <= grant_d;
    ptr_q     <= ptr_d;
  end

  assign mmu_valid   = valid_q;
  assign mmu_rsv_id  = rsv_id_q;
  assign mmu_data    = data_q;
  assign mmu_address = address_q;
  assign mmu_opcode  = opcode_q;
  assign grant_idx   = grant_q;
  assign ptr         = ptr_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized and directed bench for mem_request_arbiter against a
// cycle-level reference model of the round-robin output stage.
module tb_mem_request_arbiter;
  import fcpu_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   nrst;
  logic [N-1:0]           req_valid;
  logic [N*RSV_ID_W-1:0]  req_rsv_id;
  logic [N*DATA_W-1:0]    req_data;
  logic [N*DATA_W-1:0]    req_address;
  logic [N*INSTR_W-1:0]   req_opcode;
  logic [N-1:0]           req_ready;
  logic                   mmu_valid;
  logic [RSV_ID_W-1:0]    mmu_rsv_id;
  logic [DATA_W-1:0]      mmu_data;
  logic [DATA_W-1:0]      mmu_address;
  logic [INSTR_W-1:0]     mmu_opcode;
  logic                   mmu_ready;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          ptr;

  logic [RSV_ID_W-1:0] rsv  [N];
  logic [DATA_W-1:0]   dat  [N];
  logic [DATA_W-1:0]   addr [N];
  logic [INSTR_W-1:0]  op   [N];

  // Reference model state
  bit                  m_valid;
  logic [RSV_ID_W-1:0] m_rsv;
  logic [DATA_W-1:0]   m_data;
  logic [DATA_W-1:0]   m_addr;
  logic [INSTR_W-1:0]  m_op;
  int                  m_grant;
  int                  m_ptr;

  int n_checks = 0;
  int n_pass   = 0;

  mem_request_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_rsv_id(req_rsv_id), .req_data(req_data),
    .req_address(req_address), .req_opcode(req_opcode), .req_ready(req_ready),
    .mmu_valid(mmu_valid), .mmu_rsv_id(mmu_rsv_id), .mmu_data(mmu_data),
    .mmu_address(mmu_address), .mmu_opcode(mmu_opcode), .mmu_ready(mmu_ready),
    .grant_idx(grant_idx), .ptr(ptr)
  );

  always_comb begin
    req_rsv_id  = '0;
    req_data    = '0;
    req_address = '0;
    req_opcode  = '0;
    for (int i = 0; i < N; i++) begin
      req_rsv_id[i*RSV_ID_W +: RSV_ID_W] = rsv[i];
      req_data[i*DATA_W +: DATA_W]       = dat[i];
      req_address[i*DATA_W +: DATA_W]    = addr[i];
      req_opcode[i*INSTR_W +: INSTR_W]   = op[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      rsv[i]  = RSV_ID_W'($urandom);
      dat[i]  = DATA_W'($urandom);
      addr[i] = DATA_W'($urandom);
      op[i]   = INSTR_W'($urandom_range(1, 4));
    end
  endtask

  // One clock: check combinational ready, advance model, check registers.
  task automatic step();
    int w;
    logic [N-1:0] exp_ready;
    bit take;
    #1;
    w = model_winner();
    take = (w >= 0) && (!m_valid || mmu_ready) && !nrst;
    exp_ready = take ? (N'(1) << w) : '0;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (nrst) begin
      m_valid = 1'b0; m_rsv = '0; m_data = '0; m_addr = '0; m_op = '0;
      m_grant = 0; m_ptr = 0;
    end else if (take) begin
      m_valid = 1'b1;
      m_rsv = rsv[w]; m_data = dat[w]; m_addr = addr[w]; m_op = op[w];
      m_grant = w;
      m_ptr = (w + 1) % N;
    end else if (m_valid && mmu_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_eq("mmu_valid", 32'(mmu_valid), 32'(m_valid));
    check_eq("ptr", 32'(ptr), 32'(m_ptr));
    if (m_valid) begin
      check_eq("mmu_rsv_id", 32'(mmu_rsv_id), 32'(m_rsv));
      check_eq("mmu_data", 32'(mmu_data), 32'(m_data));
      check_eq("mmu_address", 32'(mmu_address), 32'(m_addr));
      check_eq("mmu_opcode", 32'(mmu_opcode), 32'(m_op));
      check_eq("grant_idx", 32'(grant_idx), 32'(m_grant));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b1; req_valid = '0; mmu_ready = 1'b0;
    step();
    nrst = 1'b0;
  endtask

  initial begin
    nrst = 1'b1; req_valid = 4'b1111; mmu_ready = 1'b0;
    rand_payload();
    m_valid = 1'b0; m_rsv = '0; m_data = '0; m_addr = '0; m_op = '0;
    m_grant = 0; m_ptr = 0;
    @(negedge clk);
    step();
    step();
    check_eq("rst_valid", 32'(mmu_valid), 32'd0);
    check_eq("rst_ptr", 32'(ptr), 32'd0);
    check_eq("rst_grant", 32'(grant_idx), 32'd0);
    check_eq("rst_addr", 32'(mmu_address), 32'd0);
    nrst = 1'b0;

    // Single request from requester 2
    rsv[2] = 4'd5; addr[2] = 16'h0100; op[2] = I_LOAD;
    req_valid = 4'b0100; mmu_ready = 1'b1;
    #1 check_eq("single_ready", 32'(req_ready), 32'h4);
    step();
    check_eq("single_addr", 32'(mmu_address), 32'h100);
    check_eq("single_grant", 32'(grant_idx), 32'd2);
    check_eq("single_ptr", 32'(ptr), 32'd3);
    req_valid = '0;
    step();

    // All requesting, full throughput
    req_valid = 4'b1111; mmu_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rand_payload();
      step();
    end

    // Backpressure after a grant to requester 1
    do_reset();
    req_valid = 4'b0010; mmu_ready = 1'b1;
    step();
    req_valid = 4'b1001; mmu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      step();
      check_eq("bp_ptr", 32'(ptr), 32'd2);
      check_eq("bp_grant", 32'(grant_idx), 32'd1);
    end
    mmu_ready = 1'b1;
    step();
    check_eq("bp_next3", 32'(grant_idx), 32'd3);
    step();
    check_eq("bp_next0", 32'(grant_idx), 32'd0);

    // Wrap from ptr 3
    do_reset();
    req_valid = 4'b0100; mmu_ready = 1'b1;
    step();
    req_valid = 4'b1001;
    step();
    check_eq("wrap_g3", 32'(grant_idx), 32'd3);
    check_eq("wrap_p0", 32'(ptr), 32'd0);
    step();
    check_eq("wrap_g0", 32'(grant_idx), 32'd0);
    check_eq("wrap_p1", 32'(ptr), 32'd1);

    // Reset mid-transfer under backpressure
    req_valid = 4'b0010; mmu_ready = 1'b0;
    step();
    step();
    nrst = 1'b1; req_valid = 4'b1111;
    #1 check_eq("midrst_ready", 32'(req_ready), 32'd0);
    step();
    check_eq("midrst_valid", 32'(mmu_valid), 32'd0);
    check_eq("midrst_ptr", 32'(ptr), 32'd0);
    check_eq("midrst_grant", 32'(grant_idx), 32'd0);
    nrst = 1'b0; mmu_ready = 1'b1;
    step();
    check_eq("midrst_first", 32'(grant_idx), 32'd0);

    // Idle gaps
    for (int i = 0; i < 12; i++) begin
      rand_payload();
      req_valid = (i % 2 == 0) ? N'($urandom_range(1, 15)) : '0;
      step();
    end

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rand_payload();
      req_valid = N'($urandom);
      mmu_ready = ($urandom_range(0, 3) != 0);
      nrst = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
